instruction_fetch: RTL and testbench

Fetch stage directly upstream of the instruction data decoder. Holds the program counter, issues one 32-bit word read at a time to instruction memory, and presents each fetched instruction to the decode stage as a 7-bit opcode plus the 25-bit `instruction_data` field (instruction bits 31:7). It has a valid/ready output handshake and accepts PC redirects from execute for branches and jumps. Only one memory request is ever outstanding.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/instruction_fetch_if.sv | 33 +++
 rtl/instruction_fetch.sv | 81 ++++++++
 tb/tb_instruction_fetch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FLUSH,
        HOLD
    } fetch_state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam int          OPCODE_W         = 7;
    localparam int          INSTR_DATA_W     = 25;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: imem request/response, execute redirect, decode output.
interface instruction_fetch_if;

    logic                              imem_req_valid;
    logic                              imem_req_ready;
    logic [31:0]                       imem_req_addr;
    logic                              imem_rsp_valid;
    logic [31:0]                       imem_rsp_data;
    logic                              redirect_valid;
    logic [31:0]                       redirect_pc;
    logic                              out_valid;
    logic                              out_ready;
    logic [31:0]                       out_pc;
    logic [fetch_pkg::OPCODE_W-1:0]     out_opcode;
    logic [fetch_pkg::INSTR_DATA_W-1:0] out_instruction_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_pc, out_opcode, out_instruction_data,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_pc, out_opcode, out_instruction_data,
        output out_ready
    );

endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem read, registered opcode/data handoff to decode,
// with execute redirects taking priority in every state.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.master bus
);

    fetch_state_t              state_q, state_d;
    logic [31:0]               pc_q, pc_d;
    logic [31:0]               out_pc_q, out_pc_d;
    logic [OPCODE_W-1:0]       out_opcode_q, out_opcode_d;
    logic [INSTR_DATA_W-1:0]   out_idata_q, out_idata_d;
    logic                      req_fire;
    logic                      rsp_take;

    // Redirect suppresses the request combinationally so a stale address never issues.
    assign bus.imem_req_valid = (state_q == REQ) && !bus.redirect_valid;
    assign bus.imem_req_addr  = pc_q;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_take           = (state_q == WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;

    assign bus.out_valid            = (state_q == HOLD);
    assign bus.out_pc               = out_pc_q;
    assign bus.out_opcode           = out_opcode_q;
    assign bus.out_instruction_data = out_idata_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        out_pc_d     = out_pc_q;
        out_opcode_d = out_opcode_q;
        out_idata_d  = out_idata_q;

        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     if (req_fire) state_d = WAIT;
            WAIT:    if (bus.imem_rsp_valid) state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = REQ;
            FLUSH:   if (bus.imem_rsp_valid) state_d = REQ;
            default: state_d = IDLE;
        endcase

        if (rsp_take) begin
            out_pc_d     = pc_q;
            out_opcode_d = bus.imem_rsp_data[OPCODE_W-1:0];
            out_idata_d  = bus.imem_rsp_data[31:OPCODE_W];
            pc_d         = pc_q + 32'(INSTR_BYTES);
        end

        // A response still in flight must be drained in FLUSH before the next request.
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
            case (state_q)
                WAIT, FLUSH: state_d = bus.imem_rsp_valid ? REQ : FLUSH;
                default:     state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            out_pc_q     <= '0;
            out_opcode_q <= '0;
            out_idata_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            out_pc_q     <= out_pc_d;
            out_opcode_q <= out_opcode_d;
            out_idata_q  <= out_idata_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed cycle table, reset pulse, then random traffic
// against a transaction-level model of fetch/redirect/handoff.
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instruction_fetch_if bus();

    instruction_fetch #(.RESET_PC(RPC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        rspv;
        logic [31:0] rspd;
        logic        ordy;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [6:0]  e_op;
        logic [24:0] e_id;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic rv, input logic [31:0] rpc, input logic rdy,
                               input logic rspv, input logic [31:0] rspd, input logic ordy,
                               input logic e_rqv, input logic [31:0] e_addr, input logic e_ov,
                               input logic [31:0] e_pc, input logic [6:0] e_op,
                               input logic [24:0] e_id);
        vec_t r;
        r.rv = rv; r.rpc = rpc; r.rdy = rdy; r.rspv = rspv; r.rspd = rspd; r.ordy = ordy;
        r.e_rqv = e_rqv; r.e_addr = e_addr; r.e_ov = e_ov; r.e_pc = e_pc;
        r.e_op = e_op; r.e_id = e_id;
        return r;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy,
                         input logic rspv, input logic [31:0] rspd, input logic ordy);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rspv;
        bus.imem_rsp_data  = rspd;
        bus.out_ready      = ordy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Random-phase model state
    logic        m_fresh, m_busy, m_stale, m_out;
    logic [31:0] m_pc, m_addr, m_out_pc, m_out_word;
    int          m_wait;

    initial begin
        logic        rv, rdy, rspv, ordy, e_rqv, hs;
        logic [31:0] rpc, old_pc;

        // Cycle table after reset release (RESET_PC = 0x100)
        vecs.push_back(v(0,0,1,0,0,1,            0,0,0,0,0,0));                          // IDLE
        vecs.push_back(v(0,0,1,0,0,1,            1,32'h100,0,0,0,0));                    // REQ 0x100
        vecs.push_back(v(0,0,1,1,32'h0051_0093,1, 0,0,0,0,0,0));                         // WAIT rsp
        vecs.push_back(v(0,0,1,0,0,1,            0,0,1,32'h100,7'h13,25'h000A201));      // HOLD
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(0,0,0,0,0,1,        1,32'h104,0,0,0,0));                    // ready low
        vecs.push_back(v(0,0,1,0,0,1,            1,32'h104,0,0,0,0));
        vecs.push_back(v(0,0,1,1,32'hDEAD_BEEF,1, 0,0,0,0,0,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(0,0,1,0,0,0,        0,0,1,32'h104,7'h6F,25'h1BD5B7D));      // back-pressure
        vecs.push_back(v(0,0,1,0,0,1,            0,0,1,32'h104,7'h6F,25'h1BD5B7D));
        vecs.push_back(v(0,0,1,0,0,1,            1,32'h108,0,0,0,0));
        vecs.push_back(v(1,32'h2002,1,0,0,1,     0,0,0,0,0,0));                          // redirect in WAIT
        vecs.push_back(v(0,0,1,0,0,1,            0,0,0,0,0,0));
        vecs.push_back(v(0,0,1,0,0,1,            0,0,0,0,0,0));
        vecs.push_back(v(0,0,1,1,32'h1234_5678,1, 0,0,0,0,0,0));                         // stale rsp
        vecs.push_back(v(0,0,1,0,0,1,            1,32'h2000,0,0,0,0));
        vecs.push_back(v(1,32'h3000,1,1,32'hCAFE_F00D,1, 0,0,0,0,0,0));                  // redirect+rsp
        vecs.push_back(v(0,0,1,0,0,1,            1,32'h3000,0,0,0,0));
        vecs.push_back(v(0,0,1,1,32'h0000_0073,1, 0,0,0,0,0,0));
        vecs.push_back(v(1,32'hFFFF_FFFF,1,0,0,1, 0,0,1,32'h3000,7'h73,25'h0));          // redirect in HOLD
        vecs.push_back(v(0,0,1,0,0,1,            1,32'hFFFF_FFFC,0,0,0,0));
        vecs.push_back(v(0,0,1,1,32'hFFFF_FFFF,1, 0,0,0,0,0,0));
        vecs.push_back(v(0,0,1,0,0,1,            0,0,1,32'hFFFF_FFFC,7'h7F,25'h1FFFFFF));
        vecs.push_back(v(1,32'h40,1,0,0,1,       0,0,0,0,0,0));                          // redirect in REQ
        vecs.push_back(v(0,0,1,0,0,1,            1,32'h40,0,0,0,0));                     // wrap target 0 skipped
        vecs.push_back(v(0,0,1,0,0,1,            0,0,0,0,0,0));                          // WAIT

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_opcode", 32'(bus.out_opcode), 32'h0);
        chk("rst_out_idata", 32'(bus.out_instruction_data), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].rv, vecs[i].rpc, vecs[i].rdy, vecs[i].rspv, vecs[i].rspd, vecs[i].ordy);
            #1;
            chk($sformatf("row%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(vecs[i].e_rqv));
            if (vecs[i].e_rqv)
                chk($sformatf("row%0d_req_addr", i), bus.imem_req_addr, vecs[i].e_addr);
            chk($sformatf("row%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                chk($sformatf("row%0d_out_pc", i), bus.out_pc, vecs[i].e_pc);
                chk($sformatf("row%0d_out_opcode", i), 32'(bus.out_opcode), 32'(vecs[i].e_op));
                chk($sformatf("row%0d_out_idata", i), 32'(bus.out_instruction_data), 32'(vecs[i].e_id));
            end
            next_cycle();
        end

        // Reset pulse while a request is outstanding (WAIT)
        drive(0, 0, 1, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("midrst_out_pc", bus.out_pc, 32'h0);
        next_cycle();
        rst_n = 1'b1;

        // Random traffic; first cycles also confirm IDLE then a fetch from RESET_PC
        m_fresh = 1'b1; m_busy = 1'b0; m_stale = 1'b0; m_out = 1'b0;
        m_pc = RPC; m_addr = '0; m_out_pc = '0; m_out_word = '0; m_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            rv   = ($urandom_range(0, 9) == 0);
            rpc  = $urandom;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | {28'h0, rpc[3:0]};
            rdy  = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            rspv = m_busy && (m_wait == 0);
            drive(rv, rpc, rdy, rspv, rspv ? mem_word(m_addr) : $urandom, ordy);
            #1;
            e_rqv = !m_busy && !m_out && !rv && !m_fresh;
            chk("rnd_req_valid", 32'(bus.imem_req_valid), 32'(e_rqv));
            if (e_rqv) chk("rnd_req_addr", bus.imem_req_addr, m_pc);
            chk("rnd_out_valid", 32'(bus.out_valid), 32'(m_out));
            if (m_out) begin
                chk("rnd_out_pc", bus.out_pc, m_out_pc);
                chk("rnd_out_opcode", 32'(bus.out_opcode), 32'(m_out_word[6:0]));
                chk("rnd_out_idata", 32'(bus.out_instruction_data), 32'(m_out_word[31:7]));
            end

            hs      = e_rqv && rdy;
            old_pc  = m_pc;
            m_fresh = 1'b0;
            if (m_out && (ordy || rv)) m_out = 1'b0;
            if (rspv) begin
                m_busy = 1'b0;
                if (!m_stale && !rv) begin
                    m_out      = 1'b1;
                    m_out_pc   = m_addr;
                    m_out_word = mem_word(m_addr);
                    m_pc       = m_addr + 32'd4;
                end
            end else if (m_busy) begin
                m_wait--;
                if (rv) m_stale = 1'b1;
            end
            if (rv) m_pc = rpc & 32'hFFFF_FFFC;
            if (hs) begin
                m_busy  = 1'b1;
                m_stale = 1'b0;
                m_addr  = old_pc;
                m_wait  = $urandom_range(0, 2);
            end
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
